// File: rtl/ibus_uncached_responder_pkg.sv
// Shared cache/bus definitions for the instruction-side memory path.
// Holds the fetch FSM state type, the word-align constant and the bus width defaults.
package ibus_uncached_responder_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 32;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned WORD_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } ibus_state_t;

endpackage

// File: rtl/ibus_uncached_responder_if.sv
// CPU-side fetch port and memory-side read handshake of the instruction bus.
// The slave modport is the responder's view; master is the surrounding IF stage + memory.
interface ibus_uncached_responder_if #(
    parameter int unsigned ADDR_W = ibus_uncached_responder_pkg::ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = ibus_uncached_responder_pkg::DATA_W_DEFAULT
) ();

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_cancel;
    logic              cpu_addr_ok;
    logic              cpu_data_ok;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_busy;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_cancel,
        output cpu_addr_ok, cpu_data_ok, cpu_rdata, cpu_busy,
        output mem_req, mem_addr,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr, cpu_cancel,
        input  cpu_addr_ok, cpu_data_ok, cpu_rdata, cpu_busy,
        input  mem_req, mem_addr,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/ibus_uncached_responder.sv
// Uncached instruction-fetch responder: one outstanding single-beat read at a time,
// with IF flushes turning an in-flight fetch into a silently drained memory read.
module ibus_uncached_responder
    import ibus_uncached_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    ibus_uncached_responder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << WORD_ALIGN_BITS) - 1);

    ibus_state_t       state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              complete;
    logic              capture;

    assign accept = ~rst & (state_q == IDLE) & bus.cpu_req & ~bus.cpu_cancel;

    // A combined addr_ok+data_ok in REQ finishes the read exactly like WAIT would.
    assign complete = ((state_q == REQ) & bus.mem_addr_ok & bus.mem_data_ok)
                    | ((state_q == WAIT) & bus.mem_data_ok);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        drop_d  = drop_q;
        capture = 1'b0;

        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                drop_d = drop_q | bus.cpu_cancel;
                if (bus.mem_addr_ok) state_d = WAIT;
            end
            WAIT:    drop_d  = drop_q | bus.cpu_cancel;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (complete) begin
            capture = ~drop_d;
            state_d = drop_d ? IDLE : RESP;
        end

        if (state_d == IDLE) drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the data register is reset too so cpu_rdata is defined.
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (accept)  addr_q  <= bus.cpu_addr & ALIGN_MASK;
            if (capture) rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.cpu_addr_ok = accept;
    assign bus.cpu_data_ok = (state_q == RESP);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_busy    = (state_q != IDLE);
    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = addr_q;

endmodule

// File: tb/tb_ibus_uncached_responder.sv
// Self-checking bench for ibus_uncached_responder: directed vector table, reset-mid-REQ
// sequence and randomized fetches judged by a transaction-level model.
module tb_ibus_uncached_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ibus_uncached_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ibus_uncached_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One fetch: memory answers addr_ok at cycle 1+a_dly, data_ok d_dly+1 cycles later
    // (d_dly = -1 means same cycle); cancel_cyc < 0 means no flush.
    typedef struct {
        logic [31:0] addr;
        int          a_dly;
        int          d_dly;
        logic [31:0] data;
        int          cancel_cyc;
        logic        exp_accept;
        logic        exp_deliver;
        logic [31:0] exp_mem_addr;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_rdata;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a flush at accept blocks the request, a flush
    // anywhere from REQ up to the data cycle kills delivery, later flushes are ignored.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   dcyc;
        r                = v;
        dcyc             = 2 + v.a_dly + v.d_dly;
        r.exp_accept     = (v.cancel_cyc != 0);
        r.exp_deliver    = r.exp_accept && !(v.cancel_cyc >= 1 && v.cancel_cyc <= dcyc);
        r.exp_mem_addr   = {v.addr[31:2], 2'b00};
        return r;
    endfunction

    // Entered and left just after a falling edge with the DUT expected in IDLE.
    task automatic run_txn(input string tag, input vec_t v);
        int          acyc, dcyc, end_exp, n_dok, dok_cyc, end_cyc;
        bit          req_bad, rdata_bad;
        logic [31:0] seen_addr, exp_final;

        acyc      = 1 + v.a_dly;
        dcyc      = acyc + 1 + v.d_dly;
        exp_final = v.exp_deliver ? v.data : prev_rdata;
        end_exp   = v.exp_deliver ? dcyc + 2 : dcyc + 1;
        req_bad   = 1'b0;
        rdata_bad = 1'b0;
        n_dok     = 0;
        dok_cyc   = -1;
        end_cyc   = -1;
        seen_addr = '0;

        bus.cpu_req     = 1'b1;
        bus.cpu_addr    = v.addr;
        bus.cpu_cancel  = (v.cancel_cyc == 0);
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        #1;
        check({tag, " addr_ok"}, 64'(bus.cpu_addr_ok), 64'(v.exp_accept));
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req    = 1'b0;
        bus.cpu_cancel = 1'b0;

        if (!v.exp_accept) begin
            for (int c = 0; c < 3; c++) begin
                #1;
                if (bus.mem_req || bus.cpu_busy) req_bad = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            check({tag, " no mem_req"}, 64'(req_bad), 64'(0));
            check({tag, " rdata held"}, 64'(bus.cpu_rdata), 64'(prev_rdata));
            return;
        end

        for (int cyc = 1; cyc < 300; cyc++) begin
            if (cyc > dcyc && !bus.cpu_busy) begin
                end_cyc = cyc;
                break;
            end
            bus.cpu_cancel  = (cyc == v.cancel_cyc);
            bus.mem_addr_ok = (cyc == acyc);
            bus.mem_data_ok = (cyc == dcyc);
            bus.mem_rdata   = (cyc == dcyc) ? v.data : $urandom;
            #1;
            if (cyc <= acyc && !bus.mem_req) req_bad = 1'b1;
            if (cyc > acyc && bus.mem_req)   req_bad = 1'b1;
            if (cyc == acyc) seen_addr = bus.mem_addr;
            if (bus.cpu_data_ok) begin
                n_dok++;
                dok_cyc = cyc;
            end
            if (bus.cpu_rdata !== ((cyc <= dcyc) ? prev_rdata : exp_final)) rdata_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.cpu_cancel  = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;

        check({tag, " mem_addr"},     64'(seen_addr),     64'(v.exp_mem_addr));
        check({tag, " mem_req shape"}, 64'(req_bad),      64'(0));
        check({tag, " data_ok count"}, 64'(n_dok),        64'(v.exp_deliver ? 1 : 0));
        check({tag, " data_ok cycle"}, 64'(dok_cyc),      64'(v.exp_deliver ? dcyc + 1 : -1));
        check({tag, " idle cycle"},    64'(end_cyc),      64'(end_exp));
        check({tag, " rdata stable"},  64'(rdata_bad),    64'(0));
        check({tag, " rdata final"},   64'(bus.cpu_rdata), 64'(exp_final));
        prev_rdata = exp_final;
    endtask

    initial begin
        vec_t rv;
        int   dcyc;

        rst             = 1'b1;
        bus.cpu_req     = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_cancel  = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        prev_rdata      = '0;

        //            addr          a  d   data          cancel acc dlv mem_addr
        vecs[0] = '{32'hBFC0_0004, 0, 0, 32'h2402_0001, -1, 1'b1, 1'b1, 32'hBFC0_0004};
        vecs[1] = '{32'hBFC0_0006, 0, 0, 32'h3C1D_8000, -1, 1'b1, 1'b1, 32'hBFC0_0004};
        vecs[2] = '{32'h0000_1000, 3, 5, 32'h8FBF_0014, -1, 1'b1, 1'b1, 32'h0000_1000};
        vecs[3] = '{32'h0000_2008, 0, 4, 32'hDEAD_BEEF,  3, 1'b1, 1'b0, 32'h0000_2008};
        vecs[4] = '{32'h0000_200C, 0, 0, 32'h27BD_FFE8, -1, 1'b1, 1'b1, 32'h0000_200C};
        vecs[5] = '{32'h0000_3000, 0, 0, 32'h1234_5678,  0, 1'b0, 1'b0, 32'h0000_3000};
        vecs[6] = '{32'h0000_300F, 2, -1, 32'h1111_2222, -1, 1'b1, 1'b1, 32'h0000_300C};
        vecs[7] = '{32'h0000_4000, 1, 2, 32'h5555_6666,  5, 1'b1, 1'b0, 32'h0000_4000};
        vecs[8] = '{32'h0000_4004, 0, 0, 32'h7777_8888,  3, 1'b1, 1'b1, 32'h0000_4004};
        vecs[9] = '{32'h0000_4009, 3, 0, 32'h9999_AAAA,  2, 1'b1, 1'b0, 32'h0000_4008};

        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b1;
        #1;
        check("reset mem_req",  64'(bus.mem_req),     64'(0));
        check("reset busy",     64'(bus.cpu_busy),    64'(0));
        check("reset data_ok",  64'(bus.cpu_data_ok), 64'(0));
        check("reset rdata",    64'(bus.cpu_rdata),   64'(0));
        check("reset mem_addr", 64'(bus.mem_addr),    64'(0));
        check("reset addr_ok",  64'(bus.cpu_addr_ok), 64'(0));
        bus.cpu_req = 1'b0;
        rst         = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Reset while the read request is still waiting for addr_ok.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_5000;
        #1;
        check("rst seq accept", 64'(bus.cpu_addr_ok), 64'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst seq in REQ", 64'(bus.mem_req), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst seq mem_req",  64'(bus.mem_req),     64'(0));
        check("rst seq busy",     64'(bus.cpu_busy),    64'(0));
        check("rst seq data_ok",  64'(bus.cpu_data_ok), 64'(0));
        check("rst seq rdata",    64'(bus.cpu_rdata),   64'(0));
        check("rst seq mem_addr", 64'(bus.mem_addr),    64'(0));
        check("rst seq addr_ok",  64'(bus.cpu_addr_ok), 64'(0));
        bus.cpu_req = 1'b0;
        rst         = 1'b0;
        prev_rdata  = '0;
        @(negedge clk);
        run_txn("after rst", model('{32'h0000_6004, 1, 1, 32'hCAFE_F00D, -1, 1'b0, 1'b0, 32'h0}));

        for (int i = 0; i < 40; i++) begin
            rv.addr  = $urandom;
            rv.a_dly = int'($urandom_range(0, 4));
            rv.d_dly = int'($urandom_range(0, 5)) - 1;
            rv.data  = $urandom;
            dcyc     = 2 + rv.a_dly + rv.d_dly;
            rv.cancel_cyc = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, dcyc + 1));
            rv.exp_accept   = 1'b0;
            rv.exp_deliver  = 1'b0;
            rv.exp_mem_addr = '0;
            run_txn($sformatf("rnd%0d", i), model(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
